// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types.
//   operation_t    : 3-bit ALU opcode (101/110 are unused encodings)
//   alu_cmd_t      : one queued command {op, a, b}
//   issuer_state_e : state of the command issuer FSM
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;

  typedef struct packed {
    operation_t  op;
    logic [7:0]  a;
    logic [7:0]  b;
  } alu_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_NOP  = 3'd2,
    S_RST  = 3'd3,
    S_RSP  = 3'd4
  } issuer_state_e;

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   push, push_data       : write one entry (ignored when full)
//   pop, pop_data         : pop_data shows the head; pop removes it (ignored when empty)
//   full, empty           : occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module tinyalu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tinyalu_cmd_issuer.sv
// TinyALU command issuer: queues ALU commands and drives the ALU start/op/A/B
// handshake, one command in flight at a time, one in-order response per command.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/op/a/b       : command input
//   alu_start/op/a/b, alu_reset_n    : registered drive to the ALU
//   alu_done, alu_result             : ALU completion
//   rsp_valid/rsp_ready/op/result/err: registered response output
//   state_dbg                        : current FSM state
// Handshakes: a transfer happens on the posedge where valid && ready are both
// high; a producer holds valid and its payload stable until that edge, and a
// consumer may raise or drop ready at any time.
// Build option TINYALU_ISSUER_TIMEOUT_EN: abandon a command whose alu_done does
// not arrive within TIMEOUT_CYC cycles and report it with rsp_err=1.
module tinyalu_cmd_issuer
  import tinyalu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  output logic          alu_start,
  output logic [2:0]    alu_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic          alu_reset_n,
  input  logic          alu_done,
  input  logic [15:0]   alu_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [2:0]    rsp_op,
  output logic [15:0]   rsp_result,
  output logic          rsp_err,
  output issuer_state_e state_dbg
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_bad
    $error("DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_timeout_bad
    $error("TIMEOUT_CYC must be at least 1");
  end

  issuer_state_e state_q, state_d;
  alu_cmd_t      push_cmd, head;
  logic          fifo_full, fifo_empty, fifo_pop, avail_q, issue, tmo_hit;

  logic          alu_start_d, alu_reset_n_d, rsp_valid_d, rsp_err_d;
  logic [2:0]    alu_op_d, rsp_op_d;
  logic [7:0]    alu_a_d, alu_b_d;
  logic [15:0]   rsp_result_d;

  assign cmd_ready = !fifo_full && !reset;
  assign push_cmd  = '{op: operation_t'(cmd_op), a: cmd_a, b: cmd_b};
  assign state_dbg = state_q;

  tinyalu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // avail_q delays issue by one cycle after a command lands, so a command
  // written at edge N starts the ALU no earlier than edge N+2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) avail_q <= 1'b0;
    else       avail_q <= !fifo_empty;
  end

  assign issue    = (state_q == S_IDLE) && avail_q && !fifo_empty && !rsp_valid;
  assign fifo_pop = issue;

`ifdef TINYALU_ISSUER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  tmo_cnt <= '0;
    else if (state_q == S_EXEC) tmo_cnt <= tmo_cnt + 1'b1;
    else                        tmo_cnt <= '0;
  end

  // A done on the expiry edge is a normal completion.
  assign tmo_hit = (state_q == S_EXEC) && !alu_done && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      alu_start   <= 1'b0;
      alu_op      <= NO_OP;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_reset_n <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_op      <= '0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_start   <= alu_start_d;
      alu_op      <= alu_op_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      alu_reset_n <= alu_reset_n_d;
      rsp_valid   <= rsp_valid_d;
      rsp_op      <= rsp_op_d;
      rsp_result  <= rsp_result_d;
      rsp_err     <= rsp_err_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          case (head.op)
            ADD_OP, AND_OP, XOR_OP, MUL_OP: state_d = S_EXEC;
            NO_OP:                          state_d = S_NOP;
            RST_OP:                         state_d = S_RST;
            default:                        state_d = S_RSP;
          endcase
        end
      end
      S_EXEC:  if (alu_done || tmo_hit) state_d = S_RSP;
      S_NOP:   state_d = S_RSP;
      S_RST:   state_d = S_RSP;
      S_RSP:   if (rsp_valid && rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    alu_start_d   = alu_start;
    alu_op_d      = alu_op;
    alu_a_d       = alu_a;
    alu_b_d       = alu_b;
    alu_reset_n_d = 1'b1;  // only an issued rst_op pulls it low, for one cycle
    rsp_valid_d   = rsp_valid;
    rsp_op_d      = rsp_op;
    rsp_result_d  = rsp_result;
    rsp_err_d     = rsp_err;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          alu_op_d     = head.op;
          alu_a_d      = head.a;
          alu_b_d      = head.b;
          rsp_op_d     = head.op;
          rsp_result_d = '0;
          rsp_err_d    = 1'b0;
          case (head.op)
            ADD_OP, AND_OP, XOR_OP, MUL_OP, NO_OP: alu_start_d = 1'b1;
            RST_OP: begin
              alu_start_d   = 1'b0;
              alu_reset_n_d = 1'b0;
            end
            default: rsp_valid_d = 1'b1;  // unused opcode: answer at once
          endcase
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          alu_start_d  = 1'b0;
          rsp_result_d = alu_result;
          rsp_valid_d  = 1'b1;
        end else if (tmo_hit) begin
          alu_start_d  = 1'b0;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
        end
      end
      S_NOP: begin
        alu_start_d = 1'b0;
        rsp_valid_d = 1'b1;
      end
      S_RST: begin
        rsp_valid_d = 1'b1;
      end
      S_RSP: begin
        if (rsp_valid && rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Bench for tinyalu_cmd_issuer with a behavioural TinyALU attached
// (add/and/xor: done 1 cycle after start, mul: 3 cycles, done is a 1-cycle pulse).
module tb_tinyalu_cmd_issuer;
  import tinyalu_pkg::*;

  logic          clk;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_a, cmd_b;
  logic          alu_start, alu_reset_n, alu_done;
  logic [2:0]    alu_op;
  logic [7:0]    alu_a, alu_b;
  logic [15:0]   alu_result;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [2:0]    rsp_op;
  logic [15:0]   rsp_result;
  issuer_state_e state_dbg;

  logic          model_done = 1'b0;
  logic [15:0]   model_result = '0;
  logic          done_block = 1'b0;
  int            m_cnt = 0;

  int            n_tests = 0;
  int            n_fail  = 0;

  // {op[19:17], result[16:1], err[0]}
  logic [19:0]   exp_q[$];
  // {op[10:8], cycles alu_start was high[7:0]}
  logic [10:0]   widths_q[$];
  int            rst_widths_q[$];

  assign alu_done   = model_done && !done_block;
  assign alu_result = model_result;

  tinyalu_cmd_issuer #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_reset_n (alu_reset_n),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_op      (rsp_op),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- ALU model ----------------
  always @(posedge clk) begin
    if (alu_reset_n !== 1'b1) begin
      model_done <= 1'b0;
      m_cnt      <= 0;
    end else if (model_done) begin
      model_done <= 1'b0;
    end else if (alu_start && (alu_op inside {3'b001, 3'b010, 3'b011, 3'b100})) begin
      if (m_cnt == ((alu_op == 3'b100) ? 2 : 0)) begin
        model_done   <= 1'b1;
        model_result <= ref_result(alu_op, alu_a, alu_b);
        m_cnt        <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          hi_cnt = 0, lo_cnt = 0, rl_cnt = 0;
  bit          first_pulse = 1'b1, done_seen = 1'b0;
  logic [2:0]  cur_op = '0;

  always @(negedge clk) begin
    if (reset) begin
      hi_cnt = 0; lo_cnt = 0; rl_cnt = 0; first_pulse = 1'b1; done_seen = 1'b0;
    end else begin
      // start pulse widths and spacing
      if (alu_start) begin
        if (hi_cnt == 0 && !first_pulse) check("start_gap_ge2", 32'(lo_cnt >= 2), 1);
        hi_cnt++; lo_cnt = 0; first_pulse = 1'b0; cur_op = alu_op;
      end else begin
        if (hi_cnt != 0) widths_q.push_back({cur_op, 8'(hi_cnt)});
        hi_cnt = 0; lo_cnt++;
      end
      // start held through done, dropped the cycle after
      if (alu_done && state_dbg == S_EXEC) begin
        check("start_high_at_done", alu_start, 1);
        done_seen = 1'b1;
      end else if (done_seen) begin
        check("start_low_after_done", alu_start, 0);
        done_seen = 1'b0;
      end
      // ALU reset pulses
      if (!alu_reset_n) begin
        check("start_low_in_alu_rst", alu_start, 0);
        rl_cnt++;
      end else if (rl_cnt != 0) begin
        rst_widths_q.push_back(rl_cnt);
        rl_cnt = 0;
      end
      // responses: the handshake completes at the coming posedge
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("rsp_op", rsp_op, e[19:17]);
          check("rsp_result", rsp_result, e[16:1]);
          check("rsp_err", rsp_err, e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_res, input logic exp_err);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    if (ok) exp_q.push_back({op, exp_res, exp_err});
    else    check("cmd_accept_timeout", 0, 1);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || state_dbg != S_IDLE); i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] w3 [4];
    logic [2:0]  op_r;
    logic [7:0]  a_r, b_r;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_reset_n", alu_reset_n, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_op", rsp_op, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_state", state_dbg, S_IDLE);
    step();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_alu_reset_n", alu_reset_n, 1);
    step();

    // 1: add with carry out
    rsp_ready = 1'b1;
    widths_q.delete();
    send_cmd(3'b001, 8'hFF, 8'h01, 16'h0100, 1'b0);
    wait_drain("t1_drain");
    check("t1_pulses", widths_q.size(), 1);
    if (widths_q.size() > 0) check("t1_start_width", widths_q.pop_front(), {3'b001, 8'd2});

    // 2: mul, start held until done
    widths_q.delete();
    send_cmd(3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    wait_drain("t2_drain");
    check("t2_pulses", widths_q.size(), 1);
    if (widths_q.size() > 0) check("t2_start_width", widths_q.pop_front(), {3'b100, 8'd4});

    // 3: queued and/xor/no_op/add
    widths_q.delete();
    send_cmd(3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0);
    send_cmd(3'b011, 8'hF0, 8'h3C, 16'h00CC, 1'b0);
    send_cmd(3'b000, 8'hF0, 8'h3C, 16'h0000, 1'b0);
    send_cmd(3'b001, 8'hF0, 8'h3C, 16'h012C, 1'b0);
    wait_drain("t3_drain");
    w3 = '{{3'b010, 8'd2}, {3'b011, 8'd2}, {3'b000, 8'd1}, {3'b001, 8'd2}};
    check("t3_pulses", widths_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (widths_q.size() > 0) check("t3_start_width", widths_q.pop_front(), w3[i]);
    end

    // 4: backpressure with random ALU commands
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op_r = 3'($urandom_range(1, 4));
      a_r  = 8'($urandom_range(0, 255));
      b_r  = 8'($urandom_range(0, 255));
      send_cmd(op_r, a_r, b_r, ref_result(op_r, a_r, b_r), 1'b0);
    end
    @(negedge clk);
    check("t4_full_after_5", cmd_ready, 0);
    for (int i = 0; i < 30 && !rsp_valid; i++) @(negedge clk);
    op_r = 3'($urandom_range(1, 4));
    a_r  = 8'($urandom_range(0, 255));
    b_r  = 8'($urandom_range(0, 255));
    fork
      send_cmd(op_r, a_r, b_r, ref_result(op_r, a_r, b_r), 1'b0);
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("t4_hold_valid", rsp_valid, 1);
          check("t4_hold_op", rsp_op, exp_q[0][19:17]);
          check("t4_hold_result", rsp_result, exp_q[0][16:1]);
          check("t4_hold_ready", cmd_ready, 0);
        end
        step();
        rsp_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // 5: rst_op between two adds, then an unused opcode
    rst_widths_q.delete();
    send_cmd(3'b001, 8'h10, 8'h20, 16'h0030, 1'b0);
    send_cmd(3'b111, 8'hAA, 8'h55, 16'h0000, 1'b0);
    send_cmd(3'b001, 8'h7F, 8'h01, 16'h0080, 1'b0);
    wait_drain("t5_drain");
    check("t5_rst_pulses", rst_widths_q.size(), 1);
    if (rst_widths_q.size() > 0) check("t5_rst_width", rst_widths_q.pop_front(), 1);
    widths_q.delete();
    send_cmd(3'b101, 8'h01, 8'h02, 16'h0000, 1'b0);
    wait_drain("t5_unused_drain");
    check("t5_unused_no_start", widths_q.size(), 0);

    // 6: reset in the middle of a mul
    send_cmd(3'b100, 8'h12, 8'h34, 16'h0000, 1'b0);
    for (int i = 0; i < 20 && !alu_start; i++) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_alu_start", alu_start, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_cmd_ready", cmd_ready, 0);
    check("t6_state", state_dbg, S_IDLE);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_no_rsp_after_rst", rsp_valid, 0);
    step();
    send_cmd(3'b001, 8'h01, 8'h02, 16'h0003, 1'b0);
    wait_drain("t6_recover_drain");

`ifdef TINYALU_ISSUER_TIMEOUT_EN
    widths_q.delete();
    done_block = 1'b1;
    send_cmd(3'b100, 8'h03, 8'h04, 16'h0000, 1'b1);
    wait_drain("t6_timeout_drain");
    done_block = 1'b0;
    check("t6_timeout_pulses", widths_q.size(), 1);
    if (widths_q.size() > 0) check("t6_timeout_width", widths_q.pop_front(), {3'b100, 8'd16});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    check("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
